// File: rtl/uart_rx.sv
// Purpose: 8N1 UART receiver: 2-flop line sync, mid-bit sampling FSM, small RX FIFO, DATA/STATUS read port.
// Latency: line to FSM 2 cycles; read data valid the cycle after uart_rd_i; irq registered with FIFO state.
// Backpressure: none on the line; push into a full FIFO drops the byte and sets sticky overrun.
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit between data and stop).
module uart_rx #(
    parameter int BAUDRATE   = 115200,
    parameter int F_CLK      = 576000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        uart_rx_i,
    input  logic        uart_rd_i,
    input  logic        uart_addr_i,
    output logic [31:0] uart_data_o,
    output logic        uart_irq_o
);
    localparam int CLKS_PER_BIT = F_CLK / BAUDRATE;
    localparam int HALF         = (CLKS_PER_BIT - 1) / 2;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    // Reject configurations the sampling scheme or pointer logic cannot handle.
    generate
        if (CLKS_PER_BIT < 3) begin : g_bad_cpb
            $error("uart_rx: CLKS_PER_BIT must be >= 3");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("uart_rx: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state, w_state_nxt;
    logic            r_rx_m, r_rx_s;
    logic [CW-1:0]   r_clk_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            w_cnt_done, w_clk_clr, w_bit_smp;
    logic            w_push_req, w_frame_set, w_par_set, w_par_bad;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt;
    logic            w_empty, w_full, w_rd_data, w_rd_stat, w_pop, w_push, w_ovr_set;
    logic            r_overrun, r_frame_err, r_parity_err, r_irq;
    logic [31:0]     r_data;

    assign w_cnt_done = (r_clk_cnt == CNT_LAST);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= uart_rx_i;
            r_rx_s <= r_rx_m;
        end
    end

    // Frame FSM state register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Next-state and per-cycle strobes for sampling, push and error reporting.
    always_comb begin
        w_state_nxt = r_state;
        w_clk_clr   = 1'b0;
        w_bit_smp   = 1'b0;
        w_push_req  = 1'b0;
        w_frame_set = 1'b0;
        w_par_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_clk_clr   = 1'b1;
                end
            end
            S_START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_clr   = 1'b1;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_cnt_done) begin
                    w_clk_clr = 1'b1;
                    w_bit_smp = 1'b1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_cnt_done) begin
                    w_clk_clr   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_cnt_done) begin
                    // Leave mid-stop so a start bit right after the stop bit is seen.
                    w_clk_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_frame_set = !r_rx_s;
                    w_par_set   = w_par_bad;
                    w_push_req  = r_rx_s && !w_par_bad;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bit timing counters and data shift register.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == S_IDLE || w_clk_clr) r_clk_cnt <= '0;
            else                                r_clk_cnt <= r_clk_cnt + CNT_ONE;
            if (r_state != S_DATA)              r_bit_cnt <= '0;
            else if (w_bit_smp)                 r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_bit_smp)                      r_shift[r_bit_cnt] <= r_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    // Parity bit is compared against even parity of the received byte.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || r_state == S_IDLE) r_par_bad <= 1'b0;
        else if (r_state == S_PARITY && w_cnt_done) r_par_bad <= (r_rx_s != ^r_shift);
    end
    assign w_par_bad = r_par_bad;
`else
    assign w_par_bad = 1'b0;
`endif

    // FIFO control: a pop in the same cycle makes room for a push into a full FIFO.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_rd_data = uart_rd_i && !uart_addr_i;
    assign w_rd_stat = uart_rd_i && uart_addr_i;
    assign w_pop     = w_rd_data && !w_empty;
    assign w_push    = w_push_req && (!w_full || w_pop);
    assign w_ovr_set = w_push_req && w_full && !w_pop;
    assign w_wr_nxt  = w_push ? (r_wr_ptr + PTR_ONE) : r_wr_ptr;
    assign w_rd_nxt  = w_pop  ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge sys_clk_i) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_shift;
    end

    // Pointers, sticky flags (set beats a same-cycle STATUS clear), irq and read data.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overrun    <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_irq        <= 1'b0;
            r_data       <= '0;
        end else begin
            r_wr_ptr     <= w_wr_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_overrun    <= (r_overrun    && !w_rd_stat) || w_ovr_set;
            r_frame_err  <= (r_frame_err  && !w_rd_stat) || w_frame_set;
            r_parity_err <= (r_parity_err && !w_rd_stat) || w_par_set;
            r_irq        <= (w_wr_nxt != w_rd_nxt);
            if (w_rd_data)
                r_data <= w_empty ? 32'h0 : {24'h0, r_mem[r_rd_ptr[AW-1:0]]};
            else if (w_rd_stat)
                r_data <= {27'h0, r_parity_err, r_frame_err, r_overrun, w_full, !w_empty};
        end
    end

    assign uart_data_o = r_data;
    assign uart_irq_o  = r_irq;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT = 5, FIFO_DEPTH = 4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Parity steps are compiled in only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    localparam int BAUD  = 115200;
    localparam int FCLK  = 576000;
    localparam int CPB   = FCLK / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i;
    logic        uart_rx_i;
    logic        uart_rd_i;
    logic        uart_addr_i;
    logic [31:0] uart_data_o;
    logic        uart_irq_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx #(.BAUDRATE(BAUD), .F_CLK(FCLK), .FIFO_DEPTH(4)) dut (
        .sys_clk_i  (sys_clk_i),
        .sys_rst_i  (sys_rst_i),
        .uart_rx_i  (uart_rx_i),
        .uart_rd_i  (uart_rd_i),
        .uart_addr_i(uart_addr_i),
        .uart_data_o(uart_data_o),
        .uart_irq_o (uart_irq_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk_i);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Full frame: start, 8 data bits LSB first, optional parity (even, xor flip), stop.
    task automatic send(input logic [7:0] b, input logic flip, input logic stop);
        logic [10:0] fr;
        fr = {stop, (^b) ^ flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            if (i == 9 && !PAR_EN) continue;
            uart_rx_i = fr[i];
            tick(CPB);
        end
        uart_rx_i = 1'b1;
    endtask

    task automatic rd(input logic a);
        uart_addr_i = a;
        uart_rd_i   = 1'b1;
        tick(1);
        uart_rd_i   = 1'b0;
    endtask

    initial begin
        sys_rst_i   = 1'b1;
        uart_rx_i   = 1'b1;
        uart_rd_i   = 1'b0;
        uart_addr_i = 1'b0;
        tick(3);
        sys_rst_i = 1'b0;
        tick(1);

        // Reset state
        check("rst_data", uart_data_o, 32'h0);
        check("rst_irq", {31'h0, uart_irq_o}, 32'h0);
        rd(1'b1);
        check("rst_status", uart_data_o, 32'h0);

        // Single byte 0xA5
        send(8'hA5, 1'b0, 1'b1);
        tick(4);
        check("a5_irq", {31'h0, uart_irq_o}, 32'h1);
        rd(1'b1);
        check("a5_status", uart_data_o, 32'h1);
        rd(1'b0);
        check("a5_data", uart_data_o, 32'hA5);
        check("a5_irq_fall", {31'h0, uart_irq_o}, 32'h0);
        tick(3);
        check("a5_hold", uart_data_o, 32'hA5);
        rd(1'b1);
        check("a5_status_after", uart_data_o, 32'h0);

        // Two-cycle glitch on an idle line
        uart_rx_i = 1'b0;
        tick(2);
        uart_rx_i = 1'b1;
        tick(12);
        check("glitch_irq", {31'h0, uart_irq_o}, 32'h0);
        rd(1'b1);
        check("glitch_status", uart_data_o, 32'h0);

        // Five bytes into a depth-4 FIFO
        for (int k = 1; k <= 5; k++) send(8'(k), 1'b0, 1'b1);
        tick(4);
        rd(1'b1);
        check("ovr_status", uart_data_o, 32'h7);
        rd(1'b1);
        check("ovr_status_clr", uart_data_o, 32'h3);
        for (int k = 1; k <= 4; k++) begin
            rd(1'b0);
            check($sformatf("ovr_data%0d", k), uart_data_o, 32'(k));
        end
        rd(1'b0);
        check("ovr_data_empty", uart_data_o, 32'h0);
        rd(1'b1);
        check("ovr_status_end", uart_data_o, 32'h0);

        // Frame error, then bad frame followed back-to-back by a good one
        send(8'h3C, 1'b0, 1'b0);
        tick(12);
        rd(1'b1);
        check("ferr_status", uart_data_o, 32'h8);
        check("ferr_irq", {31'h0, uart_irq_o}, 32'h0);
        send(8'h3C, 1'b0, 1'b0);
        send(8'h7E, 1'b0, 1'b1);
        tick(4);
        rd(1'b1);
        check("b2b_status", uart_data_o, 32'h9);
        rd(1'b0);
        check("b2b_data", uart_data_o, 32'h7E);

        // Reset in the middle of a frame, line still low for one cycle after
        uart_rx_i = 1'b0;
        tick(3 * CPB);
        sys_rst_i = 1'b1;
        tick(1);
        sys_rst_i = 1'b0;
        check("mid_rst_data", uart_data_o, 32'h0);
        tick(1);
        uart_rx_i = 1'b1;
        tick(12);
        check("mid_rst_irq", {31'h0, uart_irq_o}, 32'h0);
        rd(1'b1);
        check("mid_rst_status", uart_data_o, 32'h0);

`ifdef UART_RX_PARITY_EN
        // Parity: flipped bit rejected, correct bit accepted
        send(8'h03, 1'b1, 1'b1);
        tick(4);
        check("par_bad_irq", {31'h0, uart_irq_o}, 32'h0);
        rd(1'b1);
        check("par_bad_status", uart_data_o, 32'h10);
        send(8'h03, 1'b0, 1'b1);
        tick(4);
        rd(1'b1);
        check("par_ok_status", uart_data_o, 32'h1);
        rd(1'b0);
        check("par_ok_data", uart_data_o, 32'h03);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
